// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data-side SRAM responder.
package data_sram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AGE_W  = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] rdata_word;
        logic [AGE_W-1:0]  age;
    } resp_entry_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-like data bus between the memory stage (master) and its responder (slave).
interface data_sram_responder_if;
    import data_sram_pkg::*;

    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [3:0]        data_sram_wstrb;
    logic [31:0]       data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/resp_queue.sv
// In-order response FIFO; each entry ages every cycle until it is ready to answer.
module resp_queue
    import data_sram_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  resp_entry_t            push_entry,
    input  logic                   pop,
    output resp_entry_t            head,
    output logic                   full,
    output logic                   head_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    // The acceptance cycle covers the first latency cycle, so age saturates one short.
    localparam logic [AGE_W-1:0] READY_AGE = AGE_W'(LATENCY - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign do_push    = push & ~full;
    assign do_pop     = pop & (count != '0);
    assign head       = entries[head_ptr];
    assign head_ready = (count != '0) && (head.age == READY_AGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (entries[i].age != READY_AGE) entries[i].age <= entries[i].age + AGE_W'(1);
            end
            if (do_push) begin
                entries[tail_ptr] <= '{is_wr: push_entry.is_wr,
                                       rdata_word: push_entry.rdata_word,
                                       age: '0};
                tail_ptr <= ptr_inc(tail_ptr);
            end
            if (do_pop) head_ptr <= ptr_inc(head_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word array, addr_ok/data_ok handshake, in-order replies.
// Define DATA_SRAM_RESP_RAND_STALL_EN to add LFSR-driven stalls on both handshakes.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              ready_q;
    logic              addr_ok;
    logic              data_ok;
    logic              accept;
    logic              stall_a;
    logic              stall_d;
    logic              q_full;
    logic              q_head_ready;
    logic [CNT_W-1:0]  q_count;
    resp_entry_t       push_entry;
    resp_entry_t       q_head;
    logic              unused_bits;

    assign idx     = bus.data_sram_addr[IDX_W+1:2];
    assign addr_ok = ready_q & ~q_full & ~stall_a;
    assign accept  = bus.data_sram_req & addr_ok;
    assign data_ok = q_head_ready & ~stall_d;

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = data_ok;
    assign bus.data_sram_rdata   = (data_ok && !q_head.is_wr) ? q_head.rdata_word : '0;

    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:IDX_W+2],
                           bus.data_sram_addr[1:0], q_head.age, q_count};

    // Holds addr_ok low through reset and releases it one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        push_entry            = '0;
        push_entry.is_wr      = bus.data_sram_wr;
        push_entry.rdata_word = mem[idx];
    end

    resp_queue #(
        .DEPTH   (MAX_OUTST),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .rst        (reset),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (data_ok),
        .head       (q_head),
        .full       (q_full),
        .head_ready (q_head_ready),
        .count      (q_count)
    );

`ifdef DATA_SRAM_RESP_RAND_STALL_EN
    logic [15:0] lfsr;
    logic [1:0]  a_run;
    logic [1:0]  d_run;

    // Each stall kind is capped at three consecutive cycles before a forced release.
    assign stall_a = lfsr[0] & (a_run != 2'd3);
    assign stall_d = lfsr[1] & q_head_ready & (d_run != 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            a_run <= '0;
            d_run <= '0;
        end else begin
            lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            a_run <= stall_a ? a_run + 2'd1 : 2'd0;
            d_run <= stall_d ? d_run + 2'd1 : 2'd0;
        end
    end
`else
    assign stall_a = 1'b0;
    assign stall_d = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed and scoreboard checks for data_sram_responder (default and stall builds).
module tb_data_sram_responder;
    import data_sram_pkg::*;

    localparam int unsigned LAT  = 2;
    localparam int unsigned FLAT = 6;
    localparam int unsigned MAXO = 4;
`ifdef DATA_SRAM_RESP_RAND_STALL_EN
    localparam int MAX_RUN = 3;
`else
    localparam int MAX_RUN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    data_sram_responder_if bus ();
    data_sram_responder_if fbus ();

    // The long-latency instance sees the same requests as the main one.
    assign fbus.data_sram_req   = bus.data_sram_req;
    assign fbus.data_sram_wr    = bus.data_sram_wr;
    assign fbus.data_sram_size  = bus.data_sram_size;
    assign fbus.data_sram_wstrb = bus.data_sram_wstrb;
    assign fbus.data_sram_addr  = bus.data_sram_addr;
    assign fbus.data_sram_wdata = bus.data_sram_wdata;

    data_sram_responder #(.DEPTH_WORDS(1024), .MAX_OUTST(MAXO), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    data_sram_responder #(.DEPTH_WORDS(1024), .MAX_OUTST(MAXO), .LATENCY(FLAT)) u_full (
        .clk(clk), .reset(reset), .bus(fbus));

    logic [31:0] t3_addr [8]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10, 32'h10};
    logic        t3_aok  [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t3_dok  [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    logic [31:0] t3_rd   [14] = '{0, 0, 0, 0, 0, 0, 32'hA000_0000, 32'hA000_0001,
                                  32'hA000_0002, 32'hA000_0003, 0, 0, 0, 32'h1122_3344};
    logic [31:0] word_val [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                                  32'hA000_0003, 32'h1122_3344};

    logic [31:0] ref_mem [16];
    logic [31:0] sb_data [$];
    int          sb_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] s, input logic [31:0] d);
        bus.data_sram_req   = r;
        bus.data_sram_wr    = w;
        bus.data_sram_addr  = a;
        bus.data_sram_size  = sz;
        bus.data_sram_wstrb = s;
        bus.data_sram_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, SZ_WORD, 4'h0, 32'h0);
    endtask

    // One isolated request on the main instance with a fixed 2-cycle response.
    task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [3:0] s, input logic [31:0] d, input logic [31:0] want);
        drive(1'b1, w, a, sz, s, d);
        @(negedge clk);
        chk({tag, ".addr_ok"}, 32'(bus.data_sram_addr_ok), 32'd1);
        chk({tag, ".dok_acc"}, 32'(bus.data_sram_data_ok), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk({tag, ".dok_early"}, 32'(bus.data_sram_data_ok), 32'd0);
        step();
        @(negedge clk);
        chk({tag, ".data_ok"}, 32'(bus.data_sram_data_ok), 32'd1);
        chk({tag, ".rdata"}, bus.data_sram_rdata, want);
        step();
        @(negedge clk);
        chk({tag, ".dok_late"}, 32'(bus.data_sram_data_ok), 32'd0);
        chk({tag, ".rdata_idle"}, bus.data_sram_rdata, 32'd0);
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          issued;
        int          cyc;
        int          hold;
        int          arun;
        int          outst;
        int          idx;
        logic        pend;
        logic        rw;
        logic [31:0] ra;
        logic [31:0] rd;
        logic [31:0] rr;
        logic [3:0]  rs;

        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
        chk("rst.data_ok", 32'(bus.data_sram_data_ok), 32'd0);
        chk("rst.rdata", bus.data_sram_rdata, 32'd0);
        chk("rst.f_addr_ok", 32'(fbus.data_sram_addr_ok), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        @(negedge clk);
        chk("rel.addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
        chk("rel.f_addr_ok", 32'(fbus.data_sram_addr_ok), 32'd1);
        step();

`ifndef DATA_SRAM_RESP_RAND_STALL_EN
        // Single read latency and full-word return regardless of offset/size.
        xact("t1.wr", 1'b1, 32'h10, SZ_WORD, 4'hF, 32'h1122_3344, 32'h0);
        xact("t1.rd", 1'b0, 32'h13, SZ_BYTE, 4'h0, 32'h0, 32'h1122_3344);

        // Byte-enabled write immediately followed by a read of the same word.
        xact("t2.clr", 1'b1, 32'h40, SZ_WORD, 4'hF, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 32'h40, SZ_WORD, 4'b0101, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2.wr_acc", 32'(bus.data_sram_addr_ok), 32'd1);
        step();
        drive(1'b1, 1'b0, 32'h40, SZ_WORD, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2.rd_acc", 32'(bus.data_sram_addr_ok), 32'd1);
        chk("t2.dok_c1", 32'(bus.data_sram_data_ok), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("t2.wr_dok", 32'(bus.data_sram_data_ok), 32'd1);
        chk("t2.wr_rdata", bus.data_sram_rdata, 32'd0);
        step();
        @(negedge clk);
        chk("t2.rd_dok", 32'(bus.data_sram_data_ok), 32'd1);
        chk("t2.rd_rdata", bus.data_sram_rdata, 32'h00AD_00EF);
        step();
        @(negedge clk);
        chk("t2.dok_end", 32'(bus.data_sram_data_ok), 32'd0);
        step();

        xact("wrap.rd", 1'b0, 32'h0000_1040, SZ_WORD, 4'h0, 32'h0, 32'h00AD_00EF);
        xact("strb0.wr", 1'b1, 32'h10, SZ_WORD, 4'h0, 32'hFFFF_FFFF, 32'h0);
        xact("strb0.rd", 1'b0, 32'h10, SZ_WORD, 4'h0, 32'h0, 32'h1122_3344);
        for (int i = 0; i < 4; i++) begin
            xact($sformatf("pre%0d", i), 1'b1, 32'(i * 4), SZ_WORD, 4'hF, word_val[i], 32'h0);
        end
        repeat (10) step();

        // Fill the long-latency instance: 4 accepts, stall, then one more.
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(1'b1, 1'b0, t3_addr[c], SZ_WORD, 4'h0, 32'h0);
            else       idle();
            @(negedge clk);
            if (c < 8) chk($sformatf("t3.addr_ok[%0d]", c), 32'(fbus.data_sram_addr_ok), 32'(t3_aok[c]));
            chk($sformatf("t3.data_ok[%0d]", c), 32'(fbus.data_sram_data_ok), 32'(t3_dok[c]));
            chk($sformatf("t3.rdata[%0d]", c), fbus.data_sram_rdata, t3_rd[c]);
            step();
        end
        repeat (4) step();

        // Steady stream on the main instance: one response per cycle.
        for (int c = 0; c < 15; c++) begin
            if (c < 12) drive(1'b1, 1'b0, 32'((c % 5) * 4), SZ_WORD, 4'h0, 32'h0);
            else        idle();
            @(negedge clk);
            if (c < 12) chk($sformatf("t4.addr_ok[%0d]", c), 32'(bus.data_sram_addr_ok), 32'd1);
            chk($sformatf("t4.data_ok[%0d]", c), 32'(bus.data_sram_data_ok), 32'(c >= 2 && c <= 13));
            chk($sformatf("t4.rdata[%0d]", c), bus.data_sram_rdata,
                (c >= 2 && c <= 13) ? word_val[(c - 2) % 5] : 32'h0);
            step();
        end
        repeat (12) step();

        // Reset with three outstanding on the long-latency instance.
        drive(1'b1, 1'b1, 32'h14, SZ_WORD, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        chk("t5.acc0", 32'(fbus.data_sram_addr_ok), 32'd1);
        step();
        drive(1'b1, 1'b0, 32'h0, SZ_WORD, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5.acc1", 32'(fbus.data_sram_addr_ok), 32'd1);
        step();
        drive(1'b1, 1'b0, 32'h4, SZ_WORD, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5.acc2", 32'(fbus.data_sram_addr_ok), 32'd1);
        step();
        idle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5.rst_f_dok", 32'(fbus.data_sram_data_ok), 32'd0);
            chk("t5.rst_f_rdata", fbus.data_sram_rdata, 32'd0);
            chk("t5.rst_dok", 32'(bus.data_sram_data_ok), 32'd0);
            chk("t5.rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
            step();
        end
        reset = 1'b0;
        step();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t5.post_f_dok", 32'(fbus.data_sram_data_ok), 32'd0);
            chk("t5.post_f_aok", 32'(fbus.data_sram_addr_ok), 32'd1);
            chk("t5.post_dok", 32'(bus.data_sram_data_ok), 32'd0);
            step();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 32'h0, SZ_WORD, 4'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("t5.refill[%0d]", c), 32'(fbus.data_sram_addr_ok), 32'(c < 4));
            step();
        end
        idle();
        repeat (4) step();
        xact("t5.persist", 1'b0, 32'h14, SZ_WORD, 4'h0, 32'h0, 32'hCAFE_F00D);
        repeat (10) step();
`endif

        // Scoreboard run on the main instance: 16 initialising writes then random traffic.
        issued = 0; cyc = 0; hold = 0; arun = 0; pend = 1'b0;
        rw = 1'b0; ra = 32'h0; rd = 32'h0; rs = 4'h0; idx = 0;
        while ((issued < 200 || sb_data.size() != 0) && cyc < 5000) begin
            if (!pend && issued < 200 && $urandom_range(0, 3) != 0) begin
                if (issued < 16) begin
                    idx = issued; rw = 1'b1; rs = 4'hF;
                end else begin
                    idx = int'($urandom_range(0, 15)); rw = 1'($urandom_range(0, 1));
                    rs = 4'($urandom_range(0, 15));
                end
                rr = $urandom();
                ra = (rr & 32'hFFFF_F003) | (32'(idx) << 2);
                rd = $urandom();
                pend = 1'b1;
            end
            drive(pend, rw, ra, SZ_WORD, rs, rd);
            @(negedge clk);
            outst = sb_data.size();
            if (bus.data_sram_data_ok) begin
                if (sb_data.size() == 0) begin
                    chk("t6.spurious", 32'(bus.data_sram_data_ok), 32'd0);
                end else begin
                    chk("t6.rdata", bus.data_sram_rdata, sb_data[0]);
                    chk("t6.min_lat", 32'(cyc - sb_cyc[0] >= int'(LAT)), 32'd1);
                    void'(sb_data.pop_front());
                    void'(sb_cyc.pop_front());
                end
                hold = 0;
            end else begin
                chk("t6.idle_rdata", bus.data_sram_rdata, 32'd0);
                if (sb_data.size() != 0 && cyc - sb_cyc[0] >= int'(LAT)) begin
                    hold++;
                    chk("t6.hold_run", 32'(hold <= MAX_RUN), 32'd1);
                end else begin
                    hold = 0;
                end
            end
            if (!bus.data_sram_addr_ok && outst < int'(MAXO)) begin
                arun++;
                chk("t6.addr_ok_run", 32'(arun <= MAX_RUN), 32'd1);
            end else begin
                arun = 0;
            end
            if (pend && bus.data_sram_addr_ok) begin
                if (rw) begin
                    for (int b = 0; b < 4; b++) if (rs[b]) ref_mem[idx][8*b +: 8] = rd[8*b +: 8];
                    sb_data.push_back(32'h0);
                end else begin
                    sb_data.push_back(ref_mem[idx]);
                end
                sb_cyc.push_back(cyc);
                pend = 1'b0;
                issued++;
            end
            step();
            cyc++;
        end
        idle();
        chk("t6.issued", 32'(issued), 32'd200);
        chk("t6.drained", 32'(sb_data.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
